// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and a hold-time limit.
// Define ARB_LOCK_EN to add a 'lock' input that suppresses the hold-limit release.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       idx_nxt;
  logic             valid_nxt, expired_nxt;
  logic [1:0]       win_idx, cand;
  logic             win_found;
  logic             lock_active;
  logic             hold_at_max;
  logic             others_req;

`ifdef ARB_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  assign hold_at_max = (hold_cnt == CNT_W'(MAX_HOLD));
  assign others_req  = |(req & ~gnt);

  // Rotating priority scan starting just after the previous owner.
  always_comb begin
    win_idx   = last;
    win_found = 1'b0;
    cand      = last;
    for (int k = 1; k <= 4; k++) begin
      cand = 2'(int'(last) + k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    expired_nxt = 1'b0;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (en && win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'(4'b0001 << win_idx);
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
          last_nxt  = win_idx;
          hold_nxt  = CNT_W'(1);
        end else begin
          gnt_nxt   = 4'b0000;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!en || !req[gnt_idx]) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          valid_nxt = 1'b0;
          hold_nxt  = '0;
        end else if (hold_at_max && others_req && !lock_active) begin
          state_nxt   = IDLE;
          gnt_nxt     = 4'b0000;
          valid_nxt   = 1'b0;
          expired_nxt = 1'b1;
          hold_nxt    = '0;
        end else if (!hold_at_max) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Last is reset to 3 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      expired   <= 1'b0;
      last      <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      expired   <= expired_nxt;
      last      <= last_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed testbench for rr_arbiter_4 with MAX_HOLD=4; vector table plus hand-written corner sequences.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;
  localparam int NVEC     = 33;

  logic       clk;
  logic       rst;
  logic       en;
  logic       lock;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       expired;
  } vec_t;

  vec_t vecs [NVEC];

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic e, input logic [3:0] r);
    @(negedge clk);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic x);
    tests_run++;
    if (gnt !== g || gnt_idx !== i || gnt_valid !== v || expired !== x) begin
      tests_failed++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b expired=%b, expected gnt=%b idx=%0d valid=%b expired=%b",
               name, gnt, gnt_idx, gnt_valid, expired, g, i, v, x);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b1;
    en   = 1'b0;
    lock = 1'b0;
    req  = 4'b0000;

    // Each entry: inputs applied before an edge, outputs expected after it.
    vecs[0]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[27] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[28] = '{1'b1, 4'b1010, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[30] = '{1'b1, 4'b0010, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[31] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[32] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

    #12;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].en, vecs[v].req);
      checkOutput($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].valid, vecs[v].expired);
    end

    // Lone requester holds indefinitely with the counter pinned at the limit.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 4'b1000);
      checkOutput($sformatf("lone%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    tests_run++;
    if (dut.hold_cnt !== 3'(MAX_HOLD)) begin
      tests_failed++;
      $display("[TB] FAIL lone_hold_cnt: got %0d, expected %0d", dut.hold_cnt, MAX_HOLD);
    end

    // A competitor arriving at a saturated holder forces release immediately.
    applyStimulus(1'b1, 4'b1001);
    checkOutput("late_competitor_release", 4'b0000, 2'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1001);
    checkOutput("late_competitor_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("late_competitor_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("pre_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Async reset mid-grant: outputs clear without a clock edge, priority back to 0.
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    checkOutput("async_reset_midgrant", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'b1111);
    checkOutput("post_reset_priority", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
    #2;
    rst = 1'b1;
    #1;
    rst  = 1'b0;
    lock = 1'b1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 4'b0011);
      checkOutput($sformatf("lock%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    lock = 1'b0;
    applyStimulus(1'b1, 4'b0011);
    checkOutput("unlock_forced_release", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("unlock_next_owner", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- The registered grant is a one-hot decode of a 2-bit winner index, with a global enable gating all grants.
- Bounds ownership with a hold-time limit so that a continuous requester cannot starve the others.
- Sits in front of any shared datapath in the codebase that needs a single owner per cycle.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner while another request is pending. Legal range is 1 or more.
- CNT_W, $clog2(MAX_HOLD+1): width of the hold counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable. When 0, no new grant is issued and any current grant is released.
- req  input  4  request vector. Bit i is requester i; level-sensitive.
- gnt  output  4  registered one-hot grant. Equals the 2:4 decode of gnt_idx when gnt_valid=1, else 0000.
- gnt_idx  output  2  index of the current or most recent owner.
- gnt_valid  output  1  high while any grant is active.
- expired  output  1  one-cycle pulse on the cycle after a forced release caused by the hold limit.

Behaviour:
- Reset (async, rst=1):
  - gnt=0000, gnt_idx=00, gnt_valid=0, expired=0.
  - Internal last=3, so requester 0 has first priority; hold_cnt=0; state=IDLE.
- States: IDLE and GRANT. All outputs are registered.
- IDLE:
  - If en=1 and req≠0: the winner is the first set bit scanning last+1, last+2, last+3, last+4 (mod 4).
  - Next cycle: gnt_idx=winner, gnt=onehot(winner), gnt_valid=1, last=winner, hold_cnt=1, state goes to GRANT.
  - Otherwise stay in IDLE with outputs held at 0. gnt_idx keeps its old value.
  - Latency from request to grant is 1 cycle.
- GRANT, evaluated each cycle in this priority order:
  1. en=0: release. Next cycle gnt=0000, gnt_valid=0, state goes to IDLE, expired=0.
  2. req[gnt_idx]=0: voluntary release, with the same next-cycle result as case 1.
  3. hold_cnt==MAX_HOLD and any other req bit is set: forced release. Next cycle gnt=0000, gnt_valid=0, expired=1 for one cycle, state goes to IDLE.
  4. Else: keep the grant. hold_cnt increments, saturating at MAX_HOLD. A lone requester may therefore hold indefinitely.
- Handover: every release passes through one IDLE cycle with gnt=0000. The minimum gap between owners is one cycle. Arbitration runs in the IDLE cycle using the updated last value.
- Requests arriving or dropping in the same cycle as a release are sampled in the following IDLE cycle, not in the release cycle.
- gnt is never multi-hot. gnt has a bit set only if gnt_valid=1.
- If rst is asserted mid-grant, gnt drops immediately (async) and priority returns to requester 0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - Adds port "lock  input  1".
  - While gnt_valid=1 and lock=1, the hold-limit release (case 3) is suppressed and hold_cnt saturates.
  - en=0 and a voluntary release still take effect.
  - lock is ignored in IDLE.
- Without the macro: the port is absent and the hold limit always applies.

Test Plan:
- Reset and first grant: rst pulse, then en=1, req=0001. Expect gnt=0000 during reset; one cycle later gnt=0001, gnt_idx=00, gnt_valid=1.
- Rotation under full load (MAX_HOLD=4): hold req=1111 with en=1. Expect the grant sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles. Between owners expect 1 cycle of 0000 with expired=1.
- Enable gating: en=0, req=0100. Expect gnt=0000 indefinitely. Grant requester 2, then drop en. Expect gnt=0000 on the next cycle with expired=0.
- Voluntary release and priority (last=2): owner 2 drops its request while req=1010. Expect gnt=0000 for one cycle, then gnt=1000, then gnt=0010 after owner 3 releases.
- Lone requester: req=1000 held for 20 cycles. Expect gnt=1000 continuously, expired never 1, hold_cnt saturated at MAX_HOLD.
- ARB_LOCK_EN: owner 0 with lock=1 and req=0011 for 12 cycles. Expect gnt=0001 throughout. Deassert lock; expect a forced release on the next cycle and then gnt=0010.
